// File: rtl/fir_seq_pkg.sv
// Shared types and slot constants for the U/V upsampling FIR line sequencer.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_IN,
    S_COMMON,
    S_LINE_END,
    S_NEXT_LINE,
    S_DONE
  } state_e;

  localparam logic [4:0] SLOT_ENU_A   = 5'd4;
  localparam logic [4:0] SLOT_ENV_A   = 5'd5;
  localparam logic [4:0] SLOT_ENU_B   = 5'd10;
  localparam logic [4:0] SLOT_ENV_B   = 5'd11;
  localparam logic [4:0] COMMON_SLOTS = 5'd12;
  localparam logic [4:0] END_SLOTS    = 5'd18;

  typedef struct packed {
    logic sram_re;
    logic line_start;
    logic line_end;
    logic common_case;
    logic enable_U;
    logic enable_V;
    logic load_U_buffer;
    logic load_V_buffer;
    logic read_U_0;
    logic read_V_0;
    logic cycle;
    logic line_done;
    logic done;
    logic busy;
  } strobes_t;

endpackage

// File: rtl/fir_addr_gen.sv
// Line-base and word counters; forms the U/V SRAM word address for the next cycle.
module fir_addr_gen #(
  parameter int unsigned LINE_WORDS = 80,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        frame_clr,
  input  logic        line_adv,
  input  logic        word_init,
  input  logic        word_inc,
  input  logic        sel_v,
  input  logic        use_word,
  input  logic        lead_off,
  output logic [17:0] address_next,
  output logic        last_word
);

  logic [17:0] line_base_q, line_base_d;
  logic [17:0] word_q, word_d;
  logic [17:0] offset;

  // Address is built from the next-state counters so it can be registered alongside SRAM_re.
  always_comb begin
    line_base_d = line_base_q;
    word_d      = word_q;
    if (frame_clr) begin
      line_base_d = '0;
    end else if (line_adv) begin
      line_base_d = line_base_q + 18'(LINE_WORDS);
    end
    if (word_init) begin
      word_d = 18'd2;
    end else if (word_inc) begin
      word_d = word_q + 18'd1;
    end
    offset       = use_word ? word_d : {17'd0, lead_off};
    address_next = (sel_v ? V_BASE : U_BASE) + line_base_d + offset;
  end

  assign last_word = (word_q == 18'(LINE_WORDS - 1));

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      line_base_q <= '0;
      word_q      <= '0;
    end else begin
      line_base_q <= line_base_d;
      word_q      <= word_d;
    end
  end

endmodule

// File: rtl/fir_line_sequencer.sv
// Per-line sequencer for the U/V horizontal upsampling FIR: SRAM reads, buffer loads,
// shift strobes and phase flags, all registered.
module fir_line_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 80,
  parameter int unsigned NUM_LINES  = 240,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter int unsigned SRAM_LAT   = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  input  logic        stall,
  output logic [17:0] SRAM_address,
  output logic        SRAM_re,
  output logic        line_start,
  output logic        line_end,
  output logic        common_case,
  output logic        enable_U,
  output logic        enable_V,
  output logic        load_U_buffer,
  output logic        load_V_buffer,
  output logic        read_U_0,
  output logic        read_V_0,
  output logic        cycle,
  output logic        line_done,
  output logic        done,
  output logic        busy
);

  localparam int unsigned LineW    = $clog2(NUM_LINES + 1);
  localparam logic [4:0]  SlotLat  = 5'(SRAM_LAT);
  localparam logic [4:0]  LeadLast = 5'(3 + SRAM_LAT);

  state_e             state_q, state_d;
  logic [4:0]         slot_q, slot_d;
  logic               stalled_q, stalled_d;
  logic [LineW-1:0]   line_q, line_d;
  strobes_t           strb_q, strb_d;
  logic               frame_clr, line_adv, word_init, word_inc;
  logic               sel_v, use_word, lead_off, last_word;
  logic [17:0]        address_next;

  fir_addr_gen #(
    .LINE_WORDS(LINE_WORDS),
    .U_BASE    (U_BASE),
    .V_BASE    (V_BASE)
  ) u_addr_gen (
    .CLOCK_50_I  (CLOCK_50_I),
    .resetn      (resetn),
    .frame_clr   (frame_clr),
    .line_adv    (line_adv),
    .word_init   (word_init),
    .word_inc    (word_inc),
    .sel_v       (sel_v),
    .use_word    (use_word),
    .lead_off    (lead_off),
    .address_next(address_next),
    .last_word   (last_word)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    stalled_d = 1'b0;
    line_d    = line_q;
    frame_clr = 1'b0;
    line_adv  = 1'b0;
    word_init = 1'b0;
    word_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LEAD_IN;
          slot_d    = '0;
          line_d    = '0;
          frame_clr = 1'b1;
        end
      end
      S_LEAD_IN: begin
        if (slot_q == LeadLast) begin
          state_d   = S_COMMON;
          slot_d    = '0;
          word_init = 1'b1;
          stalled_d = stall;
        end else begin
          slot_d = slot_q + 5'd1;
        end
      end
      S_COMMON: begin
        // Stall is only taken on entry to slot 0, so no read is ever in flight across it.
        if (stalled_q) begin
          stalled_d = stall;
        end else if (slot_q == COMMON_SLOTS - 5'd1) begin
          word_inc = 1'b1;
          slot_d   = '0;
          if (last_word) begin
            state_d = S_LINE_END;
          end else begin
            stalled_d = stall;
          end
        end else begin
          slot_d = slot_q + 5'd1;
        end
      end
      S_LINE_END: begin
        if (slot_q == END_SLOTS - 5'd1) begin
          state_d  = S_NEXT_LINE;
          slot_d   = '0;
          line_d   = line_q + LineW'(1);
          line_adv = 1'b1;
        end else begin
          slot_d = slot_q + 5'd1;
        end
      end
      S_NEXT_LINE: begin
        if (line_q == LineW'(NUM_LINES)) begin
          state_d = S_DONE;
        end else if (!stall) begin
          state_d = S_LEAD_IN;
          slot_d  = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with state_q.
  always_comb begin
    strb_d      = '0;
    sel_v       = 1'b0;
    use_word    = 1'b0;
    lead_off    = 1'b0;
    strb_d.busy = (state_d != S_IDLE);
    unique case (state_d)
      S_LEAD_IN: begin
        strb_d.line_start = 1'b1;
        strb_d.sram_re    = (slot_d < 5'd4);
        sel_v             = slot_d[0];
        lead_off          = slot_d[1];
        strb_d.read_U_0   = (slot_d == SlotLat);
        strb_d.read_V_0   = (slot_d == SlotLat + 5'd1);
        strb_d.enable_U   = (slot_d == SlotLat + 5'd2);
        strb_d.enable_V   = (slot_d == SlotLat + 5'd3);
      end
      S_COMMON: begin
        strb_d.common_case = 1'b1;
        if (!stalled_d) begin
          strb_d.sram_re       = (slot_d < 5'd2);
          sel_v                = slot_d[0];
          use_word             = 1'b1;
          strb_d.load_U_buffer = (slot_d == SlotLat);
          strb_d.load_V_buffer = (slot_d == SlotLat + 5'd1);
          strb_d.enable_U      = (slot_d == SLOT_ENU_A) || (slot_d == SLOT_ENU_B);
          strb_d.enable_V      = (slot_d == SLOT_ENV_A) || (slot_d == SLOT_ENV_B);
          strb_d.cycle         = (slot_d >= 5'd6);
        end
      end
      S_LINE_END: begin
        strb_d.line_end = 1'b1;
        strb_d.enable_U = (slot_d == SLOT_ENU_A) || (slot_d == SLOT_ENU_B) ||
                          (slot_d == SLOT_ENU_B + 5'd6);
        strb_d.enable_V = (slot_d == SLOT_ENV_A) || (slot_d == SLOT_ENV_B) ||
                          (slot_d == SLOT_ENV_B + 5'd6);
      end
      S_NEXT_LINE: strb_d.line_done = (state_q != S_NEXT_LINE);
      S_DONE:      strb_d.done = 1'b1;
      default:     strb_d.busy = (state_d != S_IDLE);
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      stalled_q    <= 1'b0;
      line_q       <= '0;
      strb_q       <= '0;
      SRAM_address <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      stalled_q <= stalled_d;
      line_q    <= line_d;
      strb_q    <= strb_d;
      if (strb_d.sram_re) begin
        SRAM_address <= address_next;
      end
    end
  end

  assign SRAM_re       = strb_q.sram_re;
  assign line_start    = strb_q.line_start;
  assign line_end      = strb_q.line_end;
  assign common_case   = strb_q.common_case;
  assign enable_U      = strb_q.enable_U;
  assign enable_V      = strb_q.enable_V;
  assign load_U_buffer = strb_q.load_U_buffer;
  assign load_V_buffer = strb_q.load_V_buffer;
  assign read_U_0      = strb_q.read_U_0;
  assign read_V_0      = strb_q.read_V_0;
  assign cycle         = strb_q.cycle;
  assign line_done     = strb_q.line_done;
  assign done          = strb_q.done;
  assign busy          = strb_q.busy;

endmodule

// File: doc/fir_line_sequencer.md
Name: fir_line_sequencer

Overview:
- Controls the U/V horizontal upsampling FIR for one line at a time.
- Issues U and V SRAM word reads, times the FIR buffer loads and shift enables, and drives the line_start, line_end and common_case phase flags.
- Sits between the top-level colourspace-conversion FSM and the FIR datapath; the top FSM starts it once per frame and gets a done pulse back.

Parameters:
- LINE_WORDS, 80: U (and V) 16-bit words per line; 2 samples per word; minimum 3.
- NUM_LINES, 240: lines per frame.
- U_BASE, 18'd38400: SRAM word address of U plane.
- V_BASE, 18'd57600: SRAM word address of V plane.
- SRAM_LAT, 2: cycles from address issue to valid SRAM_read_data; legal range 1..3.

Ports:
- CLOCK_50_I  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when IDLE
- stall  in  1  SRAM owned by another client; honoured only at safe points
- SRAM_address  out  18  read word address
- SRAM_re  out  1  read request for this cycle
- line_start  out  1  FIR lead-in phase flag
- line_end  out  1  FIR border-replication phase flag
- common_case  out  1  FIR steady-state phase flag
- enable_U  out  1  U shift strobe
- enable_V  out  1  V shift strobe
- load_U_buffer  out  1  capture SRAM data into U input buffer
- load_V_buffer  out  1  capture SRAM data into V input buffer
- read_U_0  out  1  parallel border load, U
- read_V_0  out  1  parallel border load, V
- cycle  out  1  selects buffered sample: 0 = low byte, 1 = high byte
- line_done  out  1  one-cycle pulse after each line
- done  out  1  one-cycle pulse after the last line
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset/clock: resetn asynchronous, active-low; clock CLOCK_50_I. Reset forces state IDLE and clears all counters. All outputs reset to 0; SRAM_address resets to 18'd0.
- Strobes are registered outputs. Each is high only in the cycles listed below and 0 otherwise.
- IDLE:
  - Waits for start; start while busy is ignored.
  - On start: line = 0, line_base = 0, go to LEAD_IN.
- LEAD_IN (line_start = 1 throughout; local cnt 0..3+SRAM_LAT):
  - cnt 0: SRAM_re, address U_BASE+line_base.
  - cnt 1: address V_BASE+line_base.
  - cnt 2: address U_BASE+line_base+1.
  - cnt 3: address V_BASE+line_base+1.
  - cnt 0+SRAM_LAT: read_U_0. cnt 1+SRAM_LAT: read_V_0.
  - cnt 2+SRAM_LAT: enable_U. cnt 3+SRAM_LAT: enable_V.
  - After the last cnt: word = 2, slot = 0, go to COMMON.
- COMMON (common_case = 1; slot 0..11):
  - slot 0: SRAM_re, address U_BASE+line_base+word.
  - slot 1: SRAM_re, address V_BASE+line_base+word.
  - slot SRAM_LAT: load_U_buffer. slot 1+SRAM_LAT: load_V_buffer.
  - enable_U at slots 4 and 10; enable_V at slots 5 and 11.
  - cycle = 1 for slots 6..11, else 0.
  - At slot 11: word++. If the new word equals LINE_WORDS, go to LINE_END; else slot = 0.
  - stall is sampled only when entering slot 0. While it is high, hold slot 0 with SRAM_re and all strobes at 0. No read is ever outstanding across a stall.
- LINE_END (line_end = 1; slot 0..17):
  - enable_U when slot mod 6 == 4; enable_V when slot mod 6 == 5 (3 pairs).
  - No SRAM reads.
  - After slot 17, go to NEXT_LINE.
- NEXT_LINE (1 cycle):
  - line_done = 1; line++; line_base += LINE_WORDS (adder only, no multiplier).
  - If the incremented line equals NUM_LINES, go to DONE.
  - Else if stall, remain in NEXT_LINE (line_done pulses once only).
  - Else go to LEAD_IN.
- DONE: done = 1 for one cycle, then go to IDLE.
- Flags: exactly one of line_start, line_end and common_case is high in LEAD_IN, LINE_END and COMMON respectively; all three are 0 elsewhere.
- Address width: 18 bits; overflow is not checked, and parameters must keep addresses below 2^18.
- Reset mid-frame: immediate return to IDLE; in-flight SRAM data is discarded, since no strobe fires after reset.
- Per-line length: (4+SRAM_LAT) + 12*(LINE_WORDS-2) + 18 + 1 cycles, plus any stall cycles.

Decomposition:
- Package fir_seq_pkg:
  - state enum {S_IDLE, S_LEAD_IN, S_COMMON, S_LINE_END, S_NEXT_LINE, S_DONE};
  - slot constants SLOT_ENU_A = 4, SLOT_ENV_A = 5, SLOT_ENU_B = 10, SLOT_ENV_B = 11, COMMON_SLOTS = 12, END_SLOTS = 18.
- Sub-module fir_addr_gen: holds line_base and word counters and produces U/V addresses from a select and word offset.

Test Plan:
- Short frame (LINE_WORDS = 4, NUM_LINES = 2, SRAM_LAT = 2), start pulse:
  - U address sequence 38400, 38401, 38402, 38403, then 38404...;
  - line_done twice, then done one cycle later;
  - total cycles match the per-line formula.
- Strobe timing check, same parameters:
  - in COMMON, load_U_buffer at slot 2 and load_V_buffer at slot 3;
  - enable_U at slots 4 and 10, enable_V at slots 5 and 11, cycle toggling at slot 6;
  - read_U_0 exactly 2 cycles after the first SRAM_re.
- Stall held 5 cycles as COMMON reaches slot 0: SRAM_re and all strobes 0 for 5 cycles, then the sequence resumes with an unchanged address.
- Stall asserted in NEXT_LINE: line_done only 1 cycle; LEAD_IN starts the cycle after stall drops; line_base = LINE_WORDS.
- resetn pulsed low mid-COMMON: all outputs 0 immediately; a following start restarts at address U_BASE.
- start asserted while busy: no effect on counters or address sequence; done count remains 1 per frame.
